// File: rtl/ysyx_lsu.sv
// Load/store unit: turns one execute-stage request at a time into an AXI4-Lite
// read or write, aligning store byte lanes and extending returned load data.
module ysyx_lsu #(
  parameter int BIT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             avalid_i,
  input  logic             ren_i,
  input  logic             wen_i,
  input  logic [BIT_W-1:0] addr_i,
  input  logic [BIT_W-1:0] wdata_i,
  input  logic [3:0]       alu_op_i,
  output logic [BIT_W-1:0] rdata_o,
  output logic             rvalid_o,
  output logic             wready_o,
  output logic             err_o,
  output logic [BIT_W-1:0] araddr_o,
  output logic             arvalid_o,
  input  logic             arready_i,
  input  logic [BIT_W-1:0] rdata_i,
  input  logic [1:0]       rresp_i,
  input  logic             rvalid_i,
  output logic             rready_o,
  output logic [BIT_W-1:0] awaddr_o,
  output logic             awvalid_o,
  input  logic             awready_i,
  output logic [BIT_W-1:0] wdata_o,
  output logic [3:0]       wstrb_o,
  output logic             wvalid_o,
  input  logic             wready_i,
  input  logic [1:0]       bresp_i,
  input  logic             bvalid_i,
  output logic             bready_o
);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_t;

  state_t           state_q, state_d;
  logic             armed_q, armed_d;
  logic [1:0]       off_q, off_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;

  logic [BIT_W-1:0] rdata_d, araddr_d, awaddr_d, wdata_d;
  logic [3:0]       wstrb_d;
  logic             rvalid_d, wready_d, err_d;
  logic             arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;

  logic             conflict, misaligned;
  logic [3:0]       size_mask;
  logic [BIT_W-1:0] shifted, load_ext;
  logic             unused_op_bit;

  assign unused_op_bit = alu_op_i[3];

  assign conflict   = (ren_i == wen_i);
  assign misaligned = (alu_op_i[1:0] == 2'b01 && addr_i[0]) ||
                      (alu_op_i[1] && addr_i[1:0] != 2'b00);
  assign size_mask  = alu_op_i[1] ? 4'b1111 : (alu_op_i[0] ? 4'b0011 : 4'b0001);

  assign shifted = rdata_i >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{(BIT_W-8){~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{(BIT_W-16){~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // armed only returns once avalid_i has been seen low, so a request held
  // through DONE is never accepted twice.
  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q | ~avalid_i;
    off_d     = off_q;
    size_d    = size_q;
    uns_d     = uns_q;
    rdata_d   = rdata_o;
    err_d     = err_o;
    rvalid_d  = 1'b0;
    wready_d  = 1'b0;
    araddr_d  = araddr_o;
    arvalid_d = arvalid_o;
    rready_d  = rready_o;
    awaddr_d  = awaddr_o;
    awvalid_d = awvalid_o;
    wdata_d   = wdata_o;
    wstrb_d   = wstrb_o;
    wvalid_d  = wvalid_o;
    bready_d  = bready_o;
    case (state_q)
      IDLE: begin
        if (avalid_i && armed_q) begin
          armed_d = 1'b0;
          off_d   = addr_i[1:0];
          size_d  = alu_op_i[1:0];
          uns_d   = alu_op_i[2];
          if (conflict || misaligned) begin
            state_d = DONE;
            err_d   = 1'b1;
            if (wen_i && !ren_i) begin
              wready_d = 1'b1;
            end else begin
              rvalid_d = 1'b1;
              rdata_d  = '0;
            end
          end else if (ren_i) begin
            state_d   = AR;
            araddr_d  = addr_i;
            arvalid_d = 1'b1;
          end else begin
            state_d   = AW_W;
            awaddr_d  = addr_i;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wdata_d   = wdata_i << {addr_i[1:0], 3'b000};
            wstrb_d   = size_mask << addr_i[1:0];
          end
        end
      end
      AR: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R;
        end
      end
      R: begin
        if (rvalid_i) begin
          rready_d = 1'b0;
          rvalid_d = 1'b1;
          err_d    = |rresp_i;
          rdata_d  = (rresp_i != 2'b00) ? '0 : load_ext;
          state_d  = DONE;
        end
      end
      AW_W: begin
        awvalid_d = awvalid_o & ~awready_i;
        wvalid_d  = wvalid_o & ~wready_i;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = B;
        end
      end
      B: begin
        if (bvalid_i) begin
          bready_d = 1'b0;
          wready_d = 1'b1;
          err_d    = |bresp_i;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      armed_q   <= 1'b1;
      off_q     <= 2'b00;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      rvalid_o  <= 1'b0;
      wready_o  <= 1'b0;
      araddr_o  <= '0;
      arvalid_o <= 1'b0;
      rready_o  <= 1'b0;
      awaddr_o  <= '0;
      awvalid_o <= 1'b0;
      wdata_o   <= '0;
      wstrb_o   <= 4'b0000;
      wvalid_o  <= 1'b0;
      bready_o  <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      off_q     <= off_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      rdata_o   <= rdata_d;
      err_o     <= err_d;
      rvalid_o  <= rvalid_d;
      wready_o  <= wready_d;
      araddr_o  <= araddr_d;
      arvalid_o <= arvalid_d;
      rready_o  <= rready_d;
      awaddr_o  <= awaddr_d;
      awvalid_o <= awvalid_d;
      wdata_o   <= wdata_d;
      wstrb_o   <= wstrb_d;
      wvalid_o  <= wvalid_d;
      bready_o  <= bready_d;
    end
  end

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed and randomized bench for ysyx_lsu; a responsive slave with
// programmable wait states and a spec-level model of each access.
module tb_ysyx_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        avalid_i, ren_i, wen_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  alu_op_i;
  logic [31:0] rdata_o;
  logic        rvalid_o, wready_o, err_o;
  logic [31:0] araddr_o;
  logic        arvalid_o, arready_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rvalid_i, rready_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o, awready_i;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wvalid_o, wready_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i, bready_o;

  always #5 clk = ~clk;

  ysyx_lsu #(.BIT_W(32)) dut (
    .clk(clk), .rst(rst),
    .avalid_i(avalid_i), .ren_i(ren_i), .wen_i(wen_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .alu_op_i(alu_op_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .wready_o(wready_o), .err_o(err_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  int checks = 0;
  int errors = 0;

  bit          req_ld, req_st;
  logic [31:0] req_addr, req_wd, req_rd;
  logic [3:0]  req_op;
  logic [1:0]  req_resp;
  int          w_ar, w_r, w_aw, w_w, w_b;

  int          res_cycle, res_arc, res_awc, res_wc;
  bit          res_rv, res_wr, res_err, res_bus, res_addr_bad, res_w_seen, res_timeout;
  logic [31:0] res_rdata, res_wdata;
  logic [3:0]  res_wstrb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycle numbering: cycle 1 is the cycle after the accept edge.
  task automatic apply_stimulus(input bit ld, input bit st, input logic [31:0] addr,
                                input logic [3:0] op, input logic [31:0] wd,
                                input logic [31:0] rd, input logic [1:0] resp,
                                input int a_ar, input int a_r, input int a_aw,
                                input int a_w, input int a_b, input bit hold);
    int c = 0, arc = 0, rc = 0, awc = 0, wc = 0, bc = 0;
    bit done = 1'b0;
    req_ld = ld; req_st = st; req_addr = addr; req_op = op;
    req_wd = wd; req_rd = rd; req_resp = resp;
    w_ar = a_ar; w_r = a_r; w_aw = a_aw; w_w = a_w; w_b = a_b;
    res_cycle = -1; res_rv = 0; res_wr = 0; res_err = 0; res_bus = 0;
    res_addr_bad = 0; res_w_seen = 0; res_timeout = 0;
    res_rdata = '0; res_wdata = '0; res_wstrb = '0;
    @(negedge clk);
    avalid_i = 1'b1; ren_i = ld; wen_i = st; addr_i = addr; alu_op_i = op; wdata_i = wd;
    rdata_i = rd; rresp_i = resp; bresp_i = resp;
    while (!done && c < 64) begin
      @(negedge clk);
      c++;
      if (arvalid_o || awvalid_o || wvalid_o) res_bus = 1'b1;
      if (arvalid_o && araddr_o !== addr) res_addr_bad = 1'b1;
      if (awvalid_o && awaddr_o !== addr) res_addr_bad = 1'b1;
      if (wvalid_o && !res_w_seen) begin
        res_w_seen = 1'b1;
        res_wdata  = wdata_o;
        res_wstrb  = wstrb_o;
      end
      if (rvalid_o || wready_o) begin
        done      = 1'b1;
        res_cycle = c;
        res_rv    = rvalid_o;
        res_wr    = wready_o;
        res_rdata = rdata_o;
        res_err   = err_o;
        if (!hold) begin
          avalid_i = 1'b0; ren_i = 1'b0; wen_i = 1'b0;
        end
      end
      arready_i = arvalid_o && (arc >= a_ar);
      if (arvalid_o) arc++;
      rvalid_i = rready_o && (rc >= a_r);
      if (rready_o) rc++;
      awready_i = awvalid_o && (awc >= a_aw);
      if (awvalid_o) awc++;
      wready_i = wvalid_o && (wc >= a_w);
      if (wvalid_o) wc++;
      bvalid_i = bready_o && (bc >= a_b);
      if (bready_o) bc++;
    end
    res_arc = arc; res_awc = awc; res_wc = wc;
    if (!done) res_timeout = 1'b1;
  endtask

  task automatic check_output(input string tag);
    int nb, off, exp_cycle;
    bit bad, exp_err;
    logic [31:0] sh, exp_rd;
    logic [3:0]  mask;
    nb  = (req_op[1:0] == 2'd0) ? 1 : ((req_op[1:0] == 2'd1) ? 2 : 4);
    off = int'(req_addr[1:0]);
    bad = (req_ld == req_st) || ((req_addr % nb) != 0);
    exp_err = bad || (req_resp != 2'b00);
    if (bad) exp_cycle = 1;
    else if (req_ld) exp_cycle = w_ar + w_r + 3;
    else exp_cycle = ((w_aw > w_w) ? w_aw : w_w) + w_b + 3;
    check({tag, ".timeout"}, res_timeout, 0);
    check({tag, ".cycle"}, res_cycle, exp_cycle);
    check({tag, ".err"}, res_err, exp_err);
    check({tag, ".bus"}, res_bus, !bad);
    if (req_ld && !req_st) begin
      check({tag, ".rvalid"}, res_rv, 1);
      check({tag, ".wready"}, res_wr, 0);
      sh = req_rd >> (8 * off);
      case (nb)
        1: begin
          exp_rd = sh & 32'hFF;
          if (!req_op[2] && exp_rd >= 128) exp_rd += 32'hFFFF_FF00;
        end
        2: begin
          exp_rd = sh & 32'hFFFF;
          if (!req_op[2] && exp_rd >= 32768) exp_rd += 32'hFFFF_0000;
        end
        default: exp_rd = sh;
      endcase
      if (exp_err) exp_rd = 0;
      check({tag, ".rdata"}, res_rdata, exp_rd);
      if (!bad) check({tag, ".ar_cycles"}, res_arc, w_ar + 1);
    end else if (req_st && !req_ld) begin
      check({tag, ".rvalid"}, res_rv, 0);
      check({tag, ".wready"}, res_wr, 1);
      if (!bad) begin
        mask = (nb == 1) ? 4'b0001 : ((nb == 2) ? 4'b0011 : 4'b1111);
        check({tag, ".wdata"}, res_wdata, req_wd << (8 * off));
        check({tag, ".wstrb"}, res_wstrb, mask << off);
        check({tag, ".aw_cycles"}, res_awc, w_aw + 1);
        check({tag, ".w_cycles"}, res_wc, w_w + 1);
      end
    end else begin
      check({tag, ".pulse"}, res_rv | res_wr, 1);
    end
    if (!bad) check({tag, ".addr"}, res_addr_bad, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          extra, sel;
    bit          rld;
    logic [3:0]  rop;
    logic [1:0]  rrsp;
    rst = 1'b0;
    avalid_i = 0; ren_i = 0; wen_i = 0; addr_i = '0; wdata_i = '0; alu_op_i = '0;
    arready_i = 0; rdata_i = '0; rresp_i = '0; rvalid_i = 0;
    awready_i = 0; wready_i = 0; bresp_i = '0; bvalid_i = 0;
    #12;
    check("reset.rdata", rdata_o, 0);
    check("reset.err", err_o, 0);
    check("reset.valids", {rvalid_o, wready_o, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}, 0);
    check("reset.wstrb", wstrb_o, 0);
    check("reset.araddr", araddr_o, 0);
    check("reset.awaddr", awaddr_o, 0);
    check("reset.wdata", wdata_o, 0);
    @(negedge clk);
    rst = 1'b1;

    apply_stimulus(1, 0, 32'h8000_0003, 4'b0000, 0, 32'h80AB_CDEF, 2'b00, 0, 0, 0, 0, 0, 0);
    check_output("ld_byte_s");
    check("ld_byte_s.value", res_rdata, 32'hFFFF_FF80);

    apply_stimulus(1, 0, 32'h8000_0002, 4'b0101, 0, 32'h1234_5678, 2'b00, 2, 0, 0, 0, 0, 0);
    check_output("ld_half_u");
    check("ld_half_u.value", res_rdata, 32'h0000_1234);

    apply_stimulus(0, 1, 32'h8000_0001, 4'b0000, 32'h0000_00A5, 0, 2'b00, 0, 0, 0, 2, 0, 0);
    check_output("st_byte");
    check("st_byte.wdata_value", res_wdata, 32'h0000_A500);
    check("st_byte.wstrb_value", res_wstrb, 4'b0010);

    apply_stimulus(1, 0, 32'h8000_0002, 4'b0010, 0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 0);
    check_output("ld_word_misaligned");
    check("ld_word_misaligned.value", res_rdata, 0);

    apply_stimulus(0, 1, 32'h8000_0004, 4'b0010, 32'hCAFE_F00D, 0, 2'b10, 0, 0, 0, 0, 0, 0);
    check_output("st_word_bresp");

    apply_stimulus(1, 1, 32'h8000_0000, 4'b0010, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    check_output("conflict_both");
    apply_stimulus(0, 0, 32'h8000_0000, 4'b0010, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    check_output("conflict_none");

    apply_stimulus(1, 0, 32'h8000_0001, 4'b1000, 0, 32'h0000_7F00, 2'b00, 1, 1, 0, 0, 0, 0);
    check_output("ld_op_bit3");
    check("ld_op_bit3.value", res_rdata, 32'h0000_007F);

    apply_stimulus(1, 0, 32'h8000_0008, 4'b0010, 0, 32'h0BAD_F00D, 2'b00, 0, 0, 0, 0, 0, 1);
    check_output("held");
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (arvalid_o || rvalid_o || awvalid_o || wvalid_o || wready_o) extra++;
    end
    check("held.no_repeat", extra, 0);
    avalid_i = 1'b0; ren_i = 1'b0;
    apply_stimulus(1, 0, 32'h8000_000C, 4'b0001, 0, 32'h0000_8001, 2'b00, 0, 0, 0, 0, 0, 0);
    check_output("held.second");

    @(negedge clk);
    avalid_i = 1'b1; ren_i = 1'b1; wen_i = 1'b0; addr_i = 32'h8000_0010; alu_op_i = 4'b0010;
    rvalid_i = 1'b0;
    for (int i = 0; i < 10 && !rready_o; i++) begin
      @(negedge clk);
      arready_i = arvalid_o;
    end
    arready_i = 1'b0;
    check("rst_mid.in_r", rready_o, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid.rdata", rdata_o, 0);
    check("rst_mid.valids", {rvalid_o, wready_o, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, err_o}, 0);
    check("rst_mid.addrs", araddr_o | awaddr_o | wdata_o | {28'd0, wstrb_o}, 0);
    @(negedge clk);
    avalid_i = 1'b0; ren_i = 1'b0;
    rst = 1'b1;
    apply_stimulus(1, 0, 32'h8000_0000, 4'b0010, 0, 32'h1357_9BDF, 2'b00, 0, 0, 0, 0, 0, 0);
    check_output("rst_mid.after");

    for (int n = 0; n < 40; n++) begin
      sel  = $urandom_range(0, 4);
      rop  = (sel == 3) ? 4'b0100 : ((sel == 4) ? 4'b0101 : 4'(sel));
      rld  = 1'($urandom_range(0, 1));
      rrsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      apply_stimulus(rld, !rld, 32'h8000_0000 + $urandom_range(0, 15), rop, $urandom, $urandom,
                     rrsp, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3), 0);
      check_output($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
